// File: rtl/axis_position_tracker_ctrl.sv
// Calibration sequencer for axis_position_tracker: learns signal min/max, derives hysteresis thresholds,
// and sequences the tracker reset. Optional auto-recalibration: AXIS_POSITION_TRACKER_CTRL_AUTO_RECAL_EN.
module axis_position_tracker_ctrl #(
   parameter int AXIS_TDATA_WIDTH = 32,
   parameter int DEFAULT_LOWER    = -10,
   parameter int DEFAULT_UPPER    = 10,
   parameter int SETTLE_CYCLES    = 2,
   parameter int RECAL_LOG2       = 20
) (
   input  logic                        aclk,
   input  logic                        aresetn,
   input  logic                        S_AXIS_tvalid,
   input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
   input  logic                        start,
   input  logic [4:0]                  calib_log2,
   input  logic [4:0]                  hyst_shift,
   output logic [AXIS_TDATA_WIDTH-1:0] lower_treshold,
   output logic [AXIS_TDATA_WIDTH-1:0] upper_treshold,
   output logic                        tracker_aresetn,
   output logic                        busy,
   output logic                        calibrated,
   output logic                        low_amplitude
);

   localparam int W  = AXIS_TDATA_WIDTH;
   localparam int WX = AXIS_TDATA_WIDTH + 2;
   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_CALIB   = 3'd1;
   localparam logic [2:0] ST_COMPUTE = 3'd2;
   localparam logic [2:0] ST_SETTLE  = 3'd3;
   localparam logic [2:0] ST_RUN     = 3'd4;

   localparam logic signed [W-1:0]  SMAX   = {1'b0, {(W-1){1'b1}}};
   localparam logic signed [W-1:0]  SMIN   = {1'b1, {(W-1){1'b0}}};
   localparam logic signed [WX-1:0] SMAX_X = {2'b00, SMAX};
   localparam logic signed [WX-1:0] SMIN_X = {2'b11, SMIN};

   logic [2:0]          state, state_nxt;
   logic signed [W-1:0] sample, min_q, max_q, lower_q, upper_q;
   logic [19:0]         beat_cnt, beat_max;
   logic [4:0]          calib_log2_q, hyst_shift_q;
   logic [SW-1:0]       settle_cnt;
   logic                calibrated_q, low_amp_q, trk_rstn_q, trk_rstn_d;
   logic                recal_hit, auto_q;
   logic signed [WX-1:0] max_x, min_x, mid_x, span_x, hyst_x, lower_x, upper_x;

   assign sample   = S_AXIS_tdata;
   assign beat_max = 20'((21'd1 << calib_log2_q) - 21'd1);

   // Threshold arithmetic carries two guard bits so mid +/- hyst can't wrap before saturation.
   assign max_x   = {{2{max_q[W-1]}}, max_q};
   assign min_x   = {{2{min_q[W-1]}}, min_q};
   assign mid_x   = (max_x + min_x) >>> 1;
   assign span_x  = max_x - min_x;
   assign hyst_x  = span_x >>> hyst_shift_q;
   assign lower_x = mid_x - hyst_x;
   assign upper_x = mid_x + hyst_x;

   function automatic logic signed [W-1:0] sat(input logic signed [WX-1:0] v);
      if (v > SMAX_X)      return SMAX;
      else if (v < SMIN_X) return SMIN;
      else                 return v[W-1:0];
   endfunction

`ifdef AXIS_POSITION_TRACKER_CTRL_AUTO_RECAL_EN
   logic [RECAL_LOG2-1:0] recal_cnt;

   assign recal_hit = (state == ST_RUN) && S_AXIS_tvalid && (&recal_cnt);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         recal_cnt <= '0;
         auto_q    <= 1'b0;
      end else begin
         if (state != ST_RUN)    recal_cnt <= '0;
         else if (S_AXIS_tvalid) recal_cnt <= recal_cnt + 1'b1;
         if (start)          auto_q <= 1'b0;
         else if (recal_hit) auto_q <= 1'b1;
      end
   end
`else
   assign recal_hit = 1'b0;
   assign auto_q    = 1'b0;
`endif

   // NOTE: every signal written in this block gets a default first, so no path leaves a latch.
   always_comb begin
      state_nxt = state;
      if (start) begin
         state_nxt = ST_CALIB;
      end else begin
         case (state)
            ST_IDLE:    state_nxt = ST_IDLE;
            ST_CALIB:   if (S_AXIS_tvalid && beat_cnt == beat_max) state_nxt = ST_COMPUTE;
            ST_COMPUTE: state_nxt = auto_q ? ST_RUN : ST_SETTLE;
            ST_SETTLE:  if (settle_cnt == SW'(SETTLE_CYCLES - 1)) state_nxt = ST_RUN;
            ST_RUN:     if (recal_hit) state_nxt = ST_CALIB;
            default:    state_nxt = ST_IDLE;
         endcase
      end
      trk_rstn_d = (state_nxt == ST_RUN)
                 | (((state_nxt == ST_IDLE) | (state_nxt == ST_CALIB)) & calibrated_q)
                 | ((state_nxt == ST_COMPUTE) & auto_q);
   end

   // NOTE: tracker_aresetn comes straight from a flop so the tracker never sees a decode glitch.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state        <= ST_IDLE;
         trk_rstn_q   <= 1'b0;
         beat_cnt     <= '0;
         settle_cnt   <= '0;
         min_q        <= SMAX;
         max_q        <= SMIN;
         calib_log2_q <= '0;
         hyst_shift_q <= '0;
         lower_q      <= W'(DEFAULT_LOWER);
         upper_q      <= W'(DEFAULT_UPPER);
         calibrated_q <= 1'b0;
         low_amp_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
         state      <= state_nxt;
         trk_rstn_q <= trk_rstn_d;
         settle_cnt <= (state == ST_SETTLE) ? settle_cnt + 1'b1 : '0;

         if (start || recal_hit) begin
            beat_cnt     <= '0;
            min_q        <= SMAX;
            max_q        <= SMIN;
            calib_log2_q <= (calib_log2 > 5'd20) ? 5'd20 : calib_log2;
            hyst_shift_q <= hyst_shift;
         end else if (state == ST_CALIB && S_AXIS_tvalid) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (sample < min_q) min_q <= sample;
            if (sample > max_q) max_q <= sample;
         end

         if (!start && state == ST_COMPUTE) begin
            lower_q      <= sat(lower_x);
            upper_q      <= sat(upper_x);
            low_amp_q    <= (span_x < 2);
            calibrated_q <= 1'b1;
         end
      end
   end

   assign lower_treshold  = lower_q;
   assign upper_treshold  = upper_q;
   assign tracker_aresetn = trk_rstn_q;
   assign busy            = (state == ST_CALIB) || (state == ST_COMPUTE) || (state == ST_SETTLE);
   assign calibrated      = calibrated_q;
   assign low_amplitude   = low_amp_q;

endmodule

// File: tb/tb_axis_position_tracker_ctrl.sv
// Directed bench for axis_position_tracker_ctrl: one task per scenario, hand-computed expectations.
module tb_axis_position_tracker_ctrl;

   localparam int W = 32;

   logic         aclk = 1'b0;
   logic         aresetn;
   logic         S_AXIS_tvalid;
   logic [W-1:0] S_AXIS_tdata;
   logic         start;
   logic [4:0]   calib_log2, hyst_shift;
   logic [W-1:0] lower_treshold, upper_treshold;
   logic         tracker_aresetn, busy, calibrated, low_amplitude;

   int n_cmp = 0;
   int n_bad = 0;

   axis_position_tracker_ctrl #(
      .AXIS_TDATA_WIDTH(W),
      .DEFAULT_LOWER   (-10),
      .DEFAULT_UPPER   (10),
      .SETTLE_CYCLES   (2),
      .RECAL_LOG2      (4)
   ) dut (
      .aclk           (aclk),
      .aresetn        (aresetn),
      .S_AXIS_tvalid  (S_AXIS_tvalid),
      .S_AXIS_tdata   (S_AXIS_tdata),
      .start          (start),
      .calib_log2     (calib_log2),
      .hyst_shift     (hyst_shift),
      .lower_treshold (lower_treshold),
      .upper_treshold (upper_treshold),
      .tracker_aresetn(tracker_aresetn),
      .busy           (busy),
      .calibrated     (calibrated),
      .low_amplitude  (low_amplitude)
   );

   always #5 aclk = ~aclk;

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic beat(input logic [W-1:0] d);
      S_AXIS_tvalid = 1'b1;
      S_AXIS_tdata  = d;
      step();
      S_AXIS_tvalid = 1'b0;
   endtask

   task automatic pulse_start(input logic [4:0] cl, input logic [4:0] hs);
      calib_log2 = cl;
      hyst_shift = hs;
      start      = 1'b1;
      step();
      start      = 1'b0;
   endtask

   task automatic test_reset();
      aresetn = 1'b0; S_AXIS_tvalid = 1'b0; S_AXIS_tdata = '0; start = 1'b0;
      calib_log2 = '0; hyst_shift = '0;
      step(); step();
      n_cmp++; if (lower_treshold !== -32'sd10) begin n_bad++; $display("FAIL reset_lower: got %0d want -10", $signed(lower_treshold)); end
      n_cmp++; if (upper_treshold !== 32'sd10) begin n_bad++; $display("FAIL reset_upper: got %0d want 10", $signed(upper_treshold)); end
      n_cmp++; if ({tracker_aresetn, busy, calibrated, low_amplitude} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags: got %b want 0000", {tracker_aresetn, busy, calibrated, low_amplitude}); end
      aresetn = 1'b1;
      step(); step(); step();
      n_cmp++; if ({tracker_aresetn, busy} !== 2'b00) begin n_bad++; $display("FAIL idle_uncal: trk/busy got %b want 00", {tracker_aresetn, busy}); end
   endtask

   task automatic test_window();
      pulse_start(5'd3, 5'd2);
      n_cmp++; if ({busy, tracker_aresetn} !== 2'b10) begin n_bad++; $display("FAIL win_calib: busy/trk got %b want 10", {busy, tracker_aresetn}); end
      beat(32'sd10); beat(32'sd5); beat(32'sd0); beat(-32'sd5); beat(-32'sd10); beat(-32'sd15); beat(32'sd0);
      beat(32'sd15);
      n_cmp++; if (lower_treshold !== -32'sd10) begin n_bad++; $display("FAIL win_compute_hold: lower got %0d want -10", $signed(lower_treshold)); end
      step();
      n_cmp++; if (lower_treshold !== -32'sd7) begin n_bad++; $display("FAIL win_lower: got %0d want -7", $signed(lower_treshold)); end
      n_cmp++; if (upper_treshold !== 32'sd7) begin n_bad++; $display("FAIL win_upper: got %0d want 7", $signed(upper_treshold)); end
      n_cmp++; if ({calibrated, low_amplitude, tracker_aresetn} !== 3'b100) begin n_bad++; $display("FAIL win_flags: cal/low/trk got %b want 100", {calibrated, low_amplitude, tracker_aresetn}); end
      step();
      n_cmp++; if ({tracker_aresetn, busy} !== 2'b01) begin n_bad++; $display("FAIL win_settle2: trk/busy got %b want 01", {tracker_aresetn, busy}); end
      step();
      n_cmp++; if ({tracker_aresetn, busy} !== 2'b10) begin n_bad++; $display("FAIL win_run: trk/busy got %b want 10", {tracker_aresetn, busy}); end
   endtask

   task automatic test_offset();
      pulse_start(5'd3, 5'd2);
      n_cmp++; if ({busy, tracker_aresetn} !== 2'b11) begin n_bad++; $display("FAIL off_recal_run: busy/trk got %b want 11", {busy, tracker_aresetn}); end
      n_cmp++; if (lower_treshold !== -32'sd7) begin n_bad++; $display("FAIL off_hold: lower got %0d want -7", $signed(lower_treshold)); end
      for (int i = 0; i < 8; i++) beat(32'(100 + 5 * i));
      n_cmp++; if (tracker_aresetn !== 1'b0) begin n_bad++; $display("FAIL off_compute_trk: got %b want 0", tracker_aresetn); end
      beat(32'sd140);
      n_cmp++; if (lower_treshold !== 32'sd109) begin n_bad++; $display("FAIL off_lower: got %0d want 109", $signed(lower_treshold)); end
      n_cmp++; if (upper_treshold !== 32'sd125) begin n_bad++; $display("FAIL off_upper: got %0d want 125", $signed(upper_treshold)); end
      step(); step();
      n_cmp++; if (tracker_aresetn !== 1'b1) begin n_bad++; $display("FAIL off_run_trk: got %b want 1", tracker_aresetn); end
   endtask

   task automatic test_flat_gaps();
      pulse_start(5'd2, 5'd2);
      for (int i = 0; i < 3; i++) begin
         beat(32'sd5);
         step();
      end
      n_cmp++; if ({busy, tracker_aresetn} !== 2'b11) begin n_bad++; $display("FAIL flat_3beats: busy/trk got %b want 11", {busy, tracker_aresetn}); end
      beat(32'sd5);
      n_cmp++; if (tracker_aresetn !== 1'b0) begin n_bad++; $display("FAIL flat_4th_compute: trk got %b want 0", tracker_aresetn); end
      step();
      n_cmp++; if (lower_treshold !== 32'sd5 || upper_treshold !== 32'sd5) begin n_bad++; $display("FAIL flat_thresh: got %0d/%0d want 5/5", $signed(lower_treshold), $signed(upper_treshold)); end
      n_cmp++; if (low_amplitude !== 1'b1) begin n_bad++; $display("FAIL flat_lowamp: got %b want 1", low_amplitude); end
      step(); step();
   endtask

   task automatic test_saturation();
      pulse_start(5'd1, 5'd0);
      beat(32'h8000_0000);
      beat(32'h7fff_ffff);
      step();
      n_cmp++; if (lower_treshold !== 32'h8000_0000) begin n_bad++; $display("FAIL sat_lower: got %h want 80000000", lower_treshold); end
      n_cmp++; if (upper_treshold !== 32'h7fff_ffff) begin n_bad++; $display("FAIL sat_upper: got %h want 7fffffff", upper_treshold); end
      n_cmp++; if (low_amplitude !== 1'b0) begin n_bad++; $display("FAIL sat_lowamp: got %b want 0", low_amplitude); end
      step(); step();
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL sat_run_busy: got %b want 0", busy); end
   endtask

   task automatic test_restart_reset();
      pulse_start(5'd2, 5'd1);
      beat(32'sd1000); beat(32'sd1000); beat(32'sd1000);
      pulse_start(5'd2, 5'd1);
      beat(32'sd20);
      n_cmp++; if ({busy, tracker_aresetn} !== 2'b11) begin n_bad++; $display("FAIL rst_cnt_cleared: busy/trk got %b want 11", {busy, tracker_aresetn}); end
      n_cmp++; if (lower_treshold !== 32'h8000_0000) begin n_bad++; $display("FAIL rst_hold: lower got %h want 80000000", lower_treshold); end
      beat(32'sd40); beat(32'sd30); beat(32'sd30);
      step();
      n_cmp++; if (lower_treshold !== 32'sd20 || upper_treshold !== 32'sd40) begin n_bad++; $display("FAIL rst_thresh: got %0d/%0d want 20/40", $signed(lower_treshold), $signed(upper_treshold)); end
      aresetn = 1'b0;
      #1;
      n_cmp++; if (lower_treshold !== -32'sd10 || upper_treshold !== 32'sd10) begin n_bad++; $display("FAIL async_thresh: got %0d/%0d want -10/10", $signed(lower_treshold), $signed(upper_treshold)); end
      n_cmp++; if ({tracker_aresetn, busy, calibrated} !== 3'b000) begin n_bad++; $display("FAIL async_flags: trk/busy/cal got %b want 000", {tracker_aresetn, busy, calibrated}); end
      step();
      aresetn = 1'b1;
      step(); step();
      n_cmp++; if ({tracker_aresetn, busy} !== 2'b00) begin n_bad++; $display("FAIL post_reset_idle: trk/busy got %b want 00", {tracker_aresetn, busy}); end
   endtask

   task automatic calib_one_beat();
      pulse_start(5'd0, 5'd0);
      beat(32'sd50);
      step(); step(); step();
      n_cmp++; if (lower_treshold !== 32'sd50 || {tracker_aresetn, busy} !== 2'b10) begin n_bad++; $display("FAIL one_beat: lower %0d trk/busy %b want 50 10", $signed(lower_treshold), {tracker_aresetn, busy}); end
   endtask

`ifdef AXIS_POSITION_TRACKER_CTRL_AUTO_RECAL_EN
   task automatic test_auto_recal();
      logic trk_dropped;
      calib_one_beat();
      for (int i = 0; i < 15; i++) beat(32'(i));
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL auto_15: busy got %b want 0", busy); end
      calib_log2 = 5'd2; hyst_shift = 5'd1;
      beat(32'sd0);
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL auto_16: busy got %b want 1", busy); end
      trk_dropped = (tracker_aresetn !== 1'b1);
      beat(32'sd0); if (tracker_aresetn !== 1'b1) trk_dropped = 1'b1;
      beat(32'sd8); if (tracker_aresetn !== 1'b1) trk_dropped = 1'b1;
      beat(32'sd4); if (tracker_aresetn !== 1'b1) trk_dropped = 1'b1;
      beat(32'sd4); if (tracker_aresetn !== 1'b1) trk_dropped = 1'b1;
      step();       if (tracker_aresetn !== 1'b1) trk_dropped = 1'b1;
      n_cmp++; if (trk_dropped !== 1'b0) begin n_bad++; $display("FAIL auto_trk_held: dropped got %b want 0", trk_dropped); end
      n_cmp++; if (busy !== 1'b0 || lower_treshold !== 32'sd0 || upper_treshold !== 32'sd8) begin n_bad++; $display("FAIL auto_result: busy %b thr %0d/%0d want 0 0/8", busy, $signed(lower_treshold), $signed(upper_treshold)); end
   endtask
`else
   task automatic test_run_hold();
      logic seen_busy;
      calib_one_beat();
      seen_busy = 1'b0;
      for (int i = 0; i < 40; i++) begin
         beat(32'(i));
         if (busy !== 1'b0) seen_busy = 1'b1;
      end
      n_cmp++; if (seen_busy !== 1'b0 || tracker_aresetn !== 1'b1) begin n_bad++; $display("FAIL run_hold: busy_seen %b trk %b want 0 1", seen_busy, tracker_aresetn); end
      n_cmp++; if (lower_treshold !== 32'sd50) begin n_bad++; $display("FAIL run_hold_thr: got %0d want 50", $signed(lower_treshold)); end
   endtask
`endif

   initial begin
      test_reset();
      test_window();
      test_offset();
      test_flat_gaps();
      test_saturation();
      test_restart_reset();
`ifdef AXIS_POSITION_TRACKER_CTRL_AUTO_RECAL_EN
      test_auto_recal();
`else
      test_run_hold();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/axis_position_tracker_ctrl.md
Name: axis_position_tracker_ctrl

Overview:
Sequencer and configurator for axis_position_tracker. Watches the same AXI-Stream sample feed during a calibration window and captures signed min/max. It then derives hysteresis thresholds around the signal midpoint and drives the tracker's lower_treshold/upper_treshold. It also holds the tracker in reset until the thresholds are valid, then releases it. Sits beside the tracker in the vibrometer datapath; software triggers it via start.

Parameters:
AXIS_TDATA_WIDTH, 32, sample/threshold width (signed two's complement)
DEFAULT_LOWER, -10, lower_treshold value out of reset
DEFAULT_UPPER, 10, upper_treshold value out of reset
SETTLE_CYCLES, 2, aclk cycles tracker_aresetn held low after new thresholds apply (>=1)
RECAL_LOG2, 20, log2 of valid beats between automatic recalibrations (optional feature only)

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
S_AXIS_tvalid  in  1  sample valid (monitor only; no tready)
S_AXIS_tdata  in  AXIS_TDATA_WIDTH  signed sample
start  in  1  single-cycle pulse: begin or restart calibration
calib_log2  in  5  calibration window = 2^calib_log2 valid beats (0..20; larger values clamp to 20)
hyst_shift  in  5  hysteresis = span >> hyst_shift
lower_treshold  out  AXIS_TDATA_WIDTH  to tracker
upper_treshold  out  AXIS_TDATA_WIDTH  to tracker
tracker_aresetn  out  1  active-low reset for tracker
busy  out  1  high in CALIB/COMPUTE/SETTLE
calibrated  out  1  thresholds derived from data at least once
low_amplitude  out  1  last calibration had span < 2

Behaviour:
- Reset (async, aresetn=0): state IDLE; lower/upper = DEFAULT_LOWER/DEFAULT_UPPER; tracker_aresetn=0; busy=0; calibrated=0; low_amplitude=0; counters cleared; min=+max_signed, max=-max_signed-1.
- IDLE: tracker_aresetn=1 if calibrated, else 0. start -> CALIB next cycle.
- CALIB: each beat with tvalid=1 updates min/max (signed compare) and increments beat_cnt. The beat where beat_cnt == 2^calib_log2-1 is included, then -> COMPUTE. tvalid=0 beats are ignored. calib_log2 is latched at start.
- start during CALIB/COMPUTE/SETTLE: restart CALIB; clear beat_cnt; reinit min/max. Thresholds unchanged.
- COMPUTE (1 cycle), all in AXIS_TDATA_WIDTH+2 bits signed:
  - mid = (max+min)>>>1 (floor)
  - span = max-min (non-negative)
  - hyst = span>>hyst_shift
  - lower = mid-hyst, upper = mid+hyst, each saturated to signed AXIS_TDATA_WIDTH range
  - Registered at end of cycle; visible on outputs the cycle after COMPUTE.
  - low_amplitude = (span<2); calibrated=1.
  - tracker_aresetn driven 0 from COMPUTE onward.
- SETTLE: tracker_aresetn=0 for SETTLE_CYCLES cycles, then -> RUN with tracker_aresetn=1.
- RUN: tracker_aresetn=1, busy=0. start -> CALIB; thresholds and tracker keep running until the next COMPUTE.
- Latency: last calibration beat at cycle T -> thresholds valid T+2, tracker_aresetn rises T+2+SETTLE_CYCLES.
- No handshake back-pressure: block never stalls the stream.

Optional Feature:
AXIS_POSITION_TRACKER_CTRL_AUTO_RECAL_EN
- Defined: in RUN, count tvalid beats; after 2^RECAL_LOG2 beats, enter CALIB automatically (calib_log2/hyst_shift relatched). On that COMPUTE, skip SETTLE and return straight to RUN; tracker_aresetn stays 1 and the tracker is not reset. A manual start still uses the SETTLE path.
- Not defined: RUN is left only via start; no recal counter logic is synthesised.

Test Plan:
- Window and thresholds: reset; start; calib_log2=3, hyst_shift=2; 8 valid samples {10,5,0,-5,-10,-15,0,15} -> lower=-7, upper=7, calibrated=1, low_amplitude=0. tracker_aresetn low exactly 2 cycles, then high.
- Offset signal: samples 100..140 step 5 (9 samples), calib_log2=3 -> window ends on the 8th sample (135): min=100, max=135, mid=117, span=35, hyst=8 -> lower=109, upper=125.
- Flat input and tvalid gaps: constant 5 with tvalid toggling 1/0, calib_log2=2 -> completes after 4 valid beats (8 cycles), lower=upper=5, low_amplitude=1.
- Saturation: samples -2^31 and 2^31-1, hyst_shift=0 -> mid=-1, lower=-2^31, upper=2^31-1.
- Restart and reset: start again mid-CALIB -> beat_cnt restarts and old thresholds are held. aresetn=0 mid-SETTLE -> immediately DEFAULT_LOWER/DEFAULT_UPPER (-10/10), tracker_aresetn=0, busy=0, calibrated=0.
- With AUTO_RECAL_EN and RECAL_LOG2=4: after 16 RUN beats -> busy=1, recalibration completes, tracker_aresetn never deasserts.
